// File: rtl/scratchpad_reader_pkg.sv
// Shared constants and types for the scratchpad reader.
// CSR map, CTRL/STATUS bit positions and FSM states.
package scratchpad_reader_pkg;

    localparam logic [1:0] CSR_SRC    = 2'd0;
    localparam logic [1:0] CSR_LEN    = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/scratchpad_reader_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Head word is visible on dout whenever count is nonzero.
module scratchpad_reader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop && !flush && (count_q != '0);

    // Storage; no reset needed because count gates what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy, cleared by reset or flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/scratchpad_reader.sv
// Scratchpad-to-stream reader with CSR control and credit-limited reads.
// Optional irq output when SCRATCHPAD_READER_IRQ_EN is defined.
module scratchpad_reader
    import scratchpad_reader_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] sp_address,
    output logic              sp_chipselect,
    output logic              sp_write,
    output logic [3:0]        sp_byteenable,
    input  logic [DATA_W-1:0] sp_readdata,
    output logic              st_valid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_last,
    input  logic              st_ready
`ifdef SCRATCHPAD_READER_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, addr_q;
    logic [ADDR_W:0]   len_q, remain_q;
    logic              done_q;
    logic              pend_q, pend_last_q;
    logic [CW-1:0]     fifo_count, in_flight;
    logic [DATA_W:0]   fifo_dout;
    logic              fifo_empty;
    logic              wr_en, wr_src, wr_len, wr_ctrl, wr_stat;
    logic              abort, start, busy, issue, drained;
    logic              unused_wdata;
`ifdef SCRATCHPAD_READER_IRQ_EN
    logic              irq_en_q;
`endif

    assign wr_en   = csr_chipselect && csr_write;
    assign wr_src  = wr_en && (csr_address == CSR_SRC);
    assign wr_len  = wr_en && (csr_address == CSR_LEN);
    assign wr_ctrl = wr_en && (csr_address == CSR_CTRL);
    assign wr_stat = wr_en && (csr_address == CSR_STATUS);

    assign busy  = (state_q != S_IDLE);
    assign abort = wr_ctrl && csr_writedata[CTRL_ABORT];
    assign start = wr_ctrl && csr_writedata[CTRL_START]
                   && !abort && !busy;

    // Words buffered plus the one in flight bound new requests
    assign in_flight  = fifo_count + CW'(pend_q);
    assign fifo_empty = (fifo_count == '0);
    assign issue      = (state_q == S_RUN)
                        && (in_flight < CW'(FIFO_DEPTH));
    assign drained    = fifo_empty && !pend_q;

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && len_q != '0) state_d = S_RUN;
            S_RUN:   if (issue && remain_q == (ADDR_W+1)'(1))
                         state_d = S_DRAIN;
            S_DRAIN: if (drained) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Control registers, read sequencing and completion flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_src && !busy) src_q <= csr_writedata[ADDR_W-1:0];
            if (wr_len && !busy) len_q <= csr_writedata[ADDR_W:0];
            if (start) begin
                addr_q   <= src_q;
                remain_q <= len_q;
            end else if (issue) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
            pend_q      <= issue && !abort;
            pend_last_q <= (remain_q == (ADDR_W+1)'(1));
            if (start)
                done_q <= (len_q == '0);
            else if (abort)
                done_q <= 1'b0;
            else if (state_q == S_DRAIN && drained)
                done_q <= 1'b1;
            else if (wr_stat && csr_writedata[STAT_DONE])
                done_q <= 1'b0;
        end
    end

`ifdef SCRATCHPAD_READER_IRQ_EN
    // Interrupt enable and registered interrupt line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= csr_writedata[CTRL_IRQ_EN];
            irq <= done_q && irq_en_q;
        end
    end
`endif

    // Zero-wait CSR read mux
    always_comb begin
        csr_readdata = '0;
        if (csr_chipselect && csr_read) begin
            unique case (1'b1)
                csr_address == CSR_SRC:
                    csr_readdata[ADDR_W-1:0] = src_q;
                csr_address == CSR_LEN:
                    csr_readdata[ADDR_W:0] = len_q;
                csr_address == CSR_CTRL: begin
`ifdef SCRATCHPAD_READER_IRQ_EN
                    csr_readdata[CTRL_IRQ_EN] = irq_en_q;
`endif
                end
                csr_address == CSR_STATUS: begin
                    csr_readdata[STAT_BUSY] = busy;
                    csr_readdata[STAT_DONE] = done_q;
                end
                default: csr_readdata = '0;
            endcase
        end
    end

    scratchpad_reader_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (abort),
        .push   (pend_q),
        .din    ({pend_last_q, sp_readdata}),
        .pop    (st_valid && st_ready),
        .dout   (fifo_dout),
        .count  (fifo_count)
    );

    assign sp_address    = addr_q;
    assign sp_chipselect = issue;
    assign sp_write      = 1'b0;
    assign sp_byteenable = 4'hF;

    assign st_valid = !fifo_empty;
    assign st_data  = fifo_dout[DATA_W-1:0];
    assign st_last  = !fifo_empty && fifo_dout[DATA_W];

    assign unused_wdata = ^csr_writedata;

endmodule

// File: tb/tb_scratchpad_reader.sv
// Self-checking bench for scratchpad_reader.
// Reference model: expected word/address queues built from SRC/LEN.
module tb_scratchpad_reader;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int D  = 4;
`ifdef SCRATCHPAD_READER_IRQ_EN
    localparam logic [31:0] IRQB = 32'd4;
`else
    localparam logic [31:0] IRQB = 32'd0;
`endif
    localparam logic [31:0] START_W = 32'd1 | IRQB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    csr_address = '0;
    logic          csr_chipselect = 1'b0;
    logic          csr_write = 1'b0;
    logic          csr_read = 1'b0;
    logic [31:0]   csr_writedata = '0;
    logic [31:0]   csr_readdata;
    logic [AW-1:0] sp_address;
    logic          sp_chipselect;
    logic          sp_write;
    logic [3:0]    sp_byteenable;
    logic [DW-1:0] sp_readdata = '0;
    logic          st_valid;
    logic [DW-1:0] st_data;
    logic          st_last;
    logic          st_ready = 1'b0;
`ifdef SCRATCHPAD_READER_IRQ_EN
    logic          irq;
`endif

    scratchpad_reader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_chipselect(csr_chipselect),
        .csr_write     (csr_write),
        .csr_read      (csr_read),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .sp_address    (sp_address),
        .sp_chipselect (sp_chipselect),
        .sp_write      (sp_write),
        .sp_byteenable (sp_byteenable),
        .sp_readdata   (sp_readdata),
        .st_valid      (st_valid),
        .st_data       (st_data),
        .st_last       (st_last),
        .st_ready      (st_ready)
`ifdef SCRATCHPAD_READER_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] seed = 32'h1357_9BDF;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            issued = 0;
    int            accepted = 0;
    int            stalls = 0;
    int            rmode = 0;
    bit            mon_en = 1'b0;
    bit            hold = 1'b0;
    logic [DW:0]   hold_v;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return seed ^ (32'(a) * 32'h9E37_79B1) ^ 32'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scratchpad model: data one cycle after the request
    always @(posedge clk) begin
        if (sp_chipselect) sp_readdata <= mem_word(sp_address);
    end

    // Downstream ready pattern, changed shortly after each edge
    always @(posedge clk) begin
        #2;
        case (rmode)
            0: st_ready = 1'b1;
            1: st_ready = ~st_ready;
            2: st_ready = 1'($urandom_range(0, 1));
            default: st_ready = 1'b0;
        endcase
    end

    // Stream, address and buffering monitor against the model queues
    always @(negedge clk) begin
        if (!mon_en) begin
            hold = 1'b0;
        end else begin
            if (sp_chipselect) begin
                check("credit", 64'((issued - accepted + 1) <= D), 64'd1);
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_req: got addr %0h expected none",
                             sp_address);
                end else begin
                    check("sp_address", sp_address, addr_q.pop_front());
                end
                issued++;
            end
            if (st_valid && !sp_chipselect && addr_q.size() > 0)
                stalls++;
            if (hold)
                check("hold", {st_valid, st_last, st_data},
                      {1'b1, hold_v});
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected none",
                             st_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("st_data", st_data, w.data);
                    check("st_last", st_last, w.last);
                end
                accepted++;
            end
            hold = st_valid && !st_ready;
            hold_v = {st_last, st_data};
        end
    end

    // CSR access tasks start and end on a falling edge
    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_chipselect = 1'b1;
        csr_write = 1'b1;
        csr_address = a;
        csr_writedata = d;
        @(negedge clk);
        csr_chipselect = 1'b0;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_chipselect = 1'b1;
        csr_read = 1'b1;
        csr_address = a;
        #1 d = csr_readdata;
        csr_chipselect = 1'b0;
        csr_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic prepare(input logic [AW-1:0] src, input int len);
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        accepted = 0;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = AW'((int'(src) + i) % (1 << AW));
            addr_q.push_back(a);
            exp_q.push_back('{data: mem_word(a), last: (i == len - 1)});
        end
    endtask

    task automatic wait_done();
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        s = '0;
        for (int i = 0; i < 3000; i++) begin
            csr_rd(2'd3, s);
            if (s[1]) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1);
        check("status_end", s, 2);
        check("words_left", exp_q.size(), 0);
        check("reqs_left", addr_q.size(), 0);
`ifdef SCRATCHPAD_READER_IRQ_EN
        @(negedge clk);
        check("irq_done", irq, 1);
`endif
    endtask

    task automatic run_xfer(input logic [AW-1:0] src, input int len,
                            input int mode);
        rmode = mode;
        prepare(src, len);
        csr_wr(2'd0, 32'(src));
        csr_wr(2'd1, 32'(len));
        csr_wr(2'd2, START_W);
        wait_done();
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } csr_vec_t;

    typedef struct {
        logic [AW-1:0] src;
        int            len;
        int            mode;
    } xfer_t;

    initial begin
        csr_vec_t    tv[12];
        xfer_t       xt[3];
        logic [31:0] r;

        tv[0]  = '{1'b0, 2'd0, 32'h0, 32'h0};
        tv[1]  = '{1'b0, 2'd1, 32'h0, 32'h0};
        tv[2]  = '{1'b0, 2'd2, 32'h0, 32'h0};
        tv[3]  = '{1'b0, 2'd3, 32'h0, 32'h0};
        tv[4]  = '{1'b1, 2'd0, 32'hFFFF_C123, 32'h0};
        tv[5]  = '{1'b0, 2'd0, 32'h0, 32'h0000_0123};
        tv[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
        tv[7]  = '{1'b0, 2'd1, 32'h0, 32'h0000_7FFF};
        tv[8]  = '{1'b1, 2'd2, IRQB, 32'h0};
        tv[9]  = '{1'b0, 2'd2, 32'h0, IRQB};
        tv[10] = '{1'b1, 2'd3, 32'h3, 32'h0};
        tv[11] = '{1'b0, 2'd3, 32'h0, 32'h0};

        xt[0] = '{14'h0010, 4, 0};
        xt[1] = '{14'h3FFE, 4, 0};
        xt[2] = '{14'h2000, 9, 2};

        seed = $urandom;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_last", st_last, 0);
        check("rst_sp_cs", sp_chipselect, 0);
        check("rst_sp_addr", sp_address, 0);
        check("sp_write", sp_write, 0);
        check("sp_be", sp_byteenable, 4'hF);
`ifdef SCRATCHPAD_READER_IRQ_EN
        check("rst_irq", irq, 0);
`endif
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (tv[i].wr) begin
                csr_wr(tv[i].a, tv[i].d);
            end else begin
                csr_rd(tv[i].a, r);
                check($sformatf("csr_vec%0d", i), r, tv[i].exp);
            end
        end

        for (int i = 0; i < 3; i++)
            run_xfer(xt[i].src, xt[i].len, xt[i].mode);

        // First-word latency and back-to-back streaming
        rmode = 0;
        prepare(14'h0200, 8);
        csr_wr(2'd0, 32'h200);
        csr_wr(2'd1, 32'd8);
        csr_wr(2'd2, START_W);
        check("lat0", st_valid, 0);
        @(negedge clk);
        check("lat1", st_valid, 0);
        @(negedge clk);
        check("lat2", st_valid, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("thru", st_valid, 1);
        end
        wait_done();

        // Toggled ready, plus writes and start ignored while busy
        rmode = 1;
        stalls = 0;
        prepare(14'h1234, 16);
        csr_wr(2'd0, 32'h1234);
        csr_wr(2'd1, 32'd16);
        csr_wr(2'd2, START_W);
        repeat (3) @(negedge clk);
        csr_wr(2'd0, 32'h55);
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd2, START_W);
        csr_rd(2'd0, r);
        check("busy_src", r, 32'h1234);
        csr_rd(2'd1, r);
        check("busy_len", r, 16);
        wait_done();
        check("stall_seen", 64'(stalls > 0), 1);

        // Zero-length start
        rmode = 0;
        csr_wr(2'd3, 32'h2);
        csr_rd(2'd3, r);
        check("done_w1c", r, 0);
        prepare(14'h0040, 0);
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, START_W);
        csr_rd(2'd3, r);
        check("len0_status", r, 2);
        repeat (3) @(negedge clk);
        check("len0_valid", st_valid, 0);

        // Abort mid-transfer after five words
        prepare(14'h0300, 32);
        csr_wr(2'd0, 32'h300);
        csr_wr(2'd1, 32'd32);
        csr_wr(2'd2, START_W);
        for (int i = 0; i < 200; i++) begin
            if (accepted >= 5) break;
            @(negedge clk);
            #1;
        end
        check("abort_reach5", 64'(accepted >= 5), 1);
        @(negedge clk);
        csr_wr(2'd2, 32'h2);
        check("abort_valid", st_valid, 0);
        csr_rd(2'd3, r);
        check("abort_status", r, 0);
        check("abort_valid2", st_valid, 0);
        check("abort_cs", sp_chipselect, 0);
        exp_q.delete();
        addr_q.delete();

        // Abort and start together: abort wins
        prepare(14'h0300, 0);
        csr_wr(2'd2, 32'h3);
        csr_rd(2'd3, r);
        check("abort_start", r, 0);
        check("abort_start_cs", sp_chipselect, 0);
        run_xfer(AW'($urandom), 2, 0);

        for (int i = 0; i < 6; i++)
            run_xfer(AW'($urandom), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, 2)));

        // Reset while draining with data held in the buffer
        rmode = 3;
        prepare(14'h0080, 3);
        csr_wr(2'd0, 32'h80);
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd2, START_W);
        repeat (6) @(negedge clk);
        csr_rd(2'd3, r);
        check("drain_busy", r, 1);
        check("drain_valid", st_valid, 1);
        mon_en = 1'b0;
        #3 reset_n = 1'b0;
        csr_chipselect = 1'b1;
        csr_read = 1'b1;
        csr_address = 2'd1;
        #1;
        check("rstm_valid", st_valid, 0);
        check("rstm_last", st_last, 0);
        check("rstm_cs", sp_chipselect, 0);
        check("rstm_addr", sp_address, 0);
        check("rstm_rdata", csr_readdata, 0);
`ifdef SCRATCHPAD_READER_IRQ_EN
        check("rstm_irq", irq, 0);
`endif
        csr_chipselect = 1'b0;
        csr_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        prepare(14'h0, 0);
        rmode = 0;
        mon_en = 1'b1;
        csr_rd(2'd0, r);
        check("rst_src", r, 0);
        csr_rd(2'd1, r);
        check("rst_len", r, 0);
        csr_rd(2'd3, r);
        check("rst_status", r, 0);
        repeat (3) @(negedge clk);
        check("post_rst_valid", st_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scratchpad_reader.md
SCRATCHPAD_READER -- requirements
Module: scratchpad_reader

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 14, scratchpad word-address width
- DATA_W, 32, word width
- FIFO_DEPTH, 4, output buffer depth (power of 2, at least 2)
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- csr_address  in  2  CSR word select
- csr_chipselect  in  1  CSR select
- csr_write  in  1  CSR write strobe
- csr_read  in  1  CSR read strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, same cycle, zero-wait
- sp_address  out  ADDR_W  scratchpad word address
- sp_chipselect  out  1  scratchpad read request
- sp_write  out  1  tied 0
- sp_byteenable  out  4  tied 4'hF
- sp_readdata  in  DATA_W  scratchpad data, valid 1 cycle after request
- st_valid  out  1  stream word valid
- st_data  out  DATA_W  stream word
- st_last  out  1  final word of transfer
- st_ready  in  1  downstream accept
REQ-003 SHALL use one clock; reset is asynchronous and active-low, ports named clk and reset_n.

Function
REQ-004 SHALL decode CSR offsets as follows:
- 0 SRC: word address, ADDR_W bits
- 1 LEN: word count, ADDR_W+1 bits
- 2 CTRL: writes only; bit0 start, bit1 abort, bit2 irq_en (irq_en stored)
- 3 STATUS: bit0 busy, bit1 done (write 1 to clear); reads of all fields are zero-extended.
REQ-005 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-006 IDLE + start with LEN!=0: load address=SRC, remaining=LEN, clear done, enter RUN.
REQ-007 Start with LEN=0 SHALL set done in the next cycle and stay in IDLE.
REQ-008 Start while busy SHALL be ignored; writes to SRC/LEN while busy SHALL be ignored.
REQ-009 RUN SHALL assert sp_chipselect only when fifo_count + outstanding < FIFO_DEPTH, then increment the address and decrement remaining.
REQ-010 sp_address SHALL wrap modulo 2^ADDR_W.
REQ-011 Read data SHALL be pushed into the FIFO exactly one cycle after its request.
REQ-012 The block SHALL enter DRAIN on the cycle after the last request issues.
REQ-013 DRAIN -> IDLE when the FIFO is empty and nothing is outstanding; done SHALL be set on that transition.
REQ-014 The stream SHALL be first-word-fall-through: transfer when st_valid && st_ready; st_valid SHALL NOT depend combinationally on st_ready.
REQ-015 st_data/st_last SHALL hold stable while st_valid && !st_ready.
REQ-016 st_last SHALL be 1 only on word LEN of the transfer.
REQ-017 Sustained throughput SHALL be 1 word/cycle with st_ready held high; first st_valid SHALL assert 2 cycles after the start write.
REQ-018 Abort SHALL do the following in any state: flush the FIFO, discard an outstanding read, go to IDLE, leave done clear. If abort and start occur in the same write, abort SHALL win.
REQ-019 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-020 On reset_n low, asynchronously:
- state=IDLE; SRC, LEN, irq_en, done = 0
- FIFO empty
- st_valid, st_last, sp_chipselect, csr_readdata = 0
- sp_address = 0
REQ-021 Reset mid-transfer SHALL discard all data with no partial stream word.

Configuration
REQ-022 With SCRATCHPAD_READER_IRQ_EN defined, output irq (1 bit) SHALL be present, registered, equal to done && irq_en.
REQ-023 Without SCRATCHPAD_READER_IRQ_EN, the irq port and the irq_en bit SHALL be absent, and CTRL bit2 SHALL read and write as 0.

Structure
REQ-024 Package scratchpad_reader_pkg SHALL hold the CSR offset constants, the STATUS/CTRL bit positions and the FSM state enum.
REQ-025 Buffering SHALL be sub-module scratchpad_reader_fifo: synchronous FIFO with count output and flush input.

Verification
REQ-026 SRC=0x10, LEN=4, start, ready=1 -> 4 reads at 0x10..0x13; stream data = memory words in order; st_last on the 4th word; done=1.
REQ-027 SRC=0x3FFE, LEN=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-028 LEN=16, st_ready toggled 1/0 each cycle -> no loss or duplication; never more than FIFO_DEPTH words buffered; sp_chipselect stalls when full.
REQ-029 LEN=0, start -> done=1 one cycle later; st_valid never asserts.
REQ-030 LEN=32, abort after 5 words -> IDLE within 1 cycle, st_valid=0, done=0; a new start with LEN=2 streams correctly.
REQ-031 reset_n pulsed low mid-DRAIN -> all outputs at reset values immediately; irq=0 (IRQ build).
